// File: rtl/gfx_pkg.sv
// Shared graphics datatypes for the vertex pipeline front end.
package gfx_pkg;

  typedef logic [31:0] fp32_t;
  typedef fp32_t [2:0] vec3_t;
  typedef fp32_t [3:0] vec4_t;

  localparam int MAT_WORDS = 16;

endpackage

// File: rtl/rd_tracker.sv
// Tags each issued memory read and replays the tag DEPTH cycles later,
// aligned with the returning data word.
module rd_tracker #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             issue_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             ret_valid,
  output logic [TAG_W-1:0] ret_tag,
  output logic             inflight
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = issue_in;
    tag_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign ret_valid = vld_q[DEPTH-1];
  assign ret_tag   = tag_q[DEPTH-1];
  assign inflight  = |vld_q;

endmodule

// File: rtl/vertex_fetch.sv
// Reads the 4x4 transform then the vertex list from scene memory and streams them
// to vertex_shader. VERTEX_FETCH_INDEX_EN adds indexed vertex fetch via idx_addr_in.
//
//   state     | meaning
//   IDLE      | waiting for start_in
//   MATRIX    | issuing the 16 matrix word reads
//   VERTS     | issuing vertex reads, 3 words per vertex
//   IDX_WAIT  | (index build) waiting for the vertex index word
//   DRAIN     | waiting for the last reads to return
module vertex_fetch
  import gfx_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] mat_addr_in,
  input  logic [ADDR_W-1:0] vtx_addr_in,
`ifdef VERTEX_FETCH_INDEX_EN
  input  logic [ADDR_W-1:0] idx_addr_in,
`endif
  input  logic [15:0]       count_in,
  input  logic              ready_in,
  output logic              mem_rd_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  fp32_t             mem_data_in,
  output logic              col_set_out,
  output vec4_t             col_out,
  output logic              valid_out,
  output vec3_t             vertex_out,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MATRIX,
    S_VERTS,
    S_DRAIN
`ifdef VERTEX_FETCH_INDEX_EN
    , S_IDX_WAIT
`endif
  } fetch_state_t;

  localparam int         TAG_W    = 4;
  localparam logic [1:0] TAG_MAT  = 2'd0;
  localparam logic [1:0] TAG_VTX  = 2'd1;
`ifdef VERTEX_FETCH_INDEX_EN
  localparam logic [1:0] TAG_IDX  = 2'd2;
`endif
  localparam logic [3:0] LAST_MAT = 4'(MAT_WORDS - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] vtx_addr_q, vtx_addr_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       vcnt_q, vcnt_d;
  logic [3:0]        mcnt_q, mcnt_d;
  logic [1:0]        word_q, word_d;
  vec4_t             col_acc_q, col_acc_d;
  vec3_t             vtx_acc_q, vtx_acc_d;
  vec4_t             col_q, col_d;
  vec3_t             vertex_q, vertex_d;
  logic              col_set_q, col_set_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef VERTEX_FETCH_INDEX_EN
  logic [ADDR_W-1:0] idx_addr_q, idx_addr_d;
  logic              go_q, go_d;
  logic [17:0]       idx_x3;
  logic [ADDR_W-1:0] idx_off;
`endif

  logic             issue_word;
  logic             mem_rd;
  logic [TAG_W-1:0] iss_tag;
  logic             ret_valid;
  logic [TAG_W-1:0] ret_tag;
  logic             inflight;
  logic [1:0]       ret_kind;
  logic [1:0]       ret_word;

  rd_tracker #(
    .TAG_W (TAG_W),
    .DEPTH (MEM_LATENCY)
  ) u_rd_tracker (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .issue_in  (mem_rd),
    .tag_in    (iss_tag),
    .ret_valid (ret_valid),
    .ret_tag   (ret_tag),
    .inflight  (inflight)
  );

  assign ret_kind = ret_tag[3:2];
  assign ret_word = ret_tag[1:0];

`ifdef VERTEX_FETCH_INDEX_EN
  // Only the low 16 index bits select a vertex; the product wraps to the address width.
  assign idx_x3  = {2'b00, mem_data_in[15:0]} * 18'd3;
  assign idx_off = ADDR_W'(idx_x3);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    vtx_addr_d = vtx_addr_q;
    count_d    = count_q;
    vcnt_d     = vcnt_q;
    mcnt_d     = mcnt_q;
    word_d     = word_q;
    col_acc_d  = col_acc_q;
    vtx_acc_d  = vtx_acc_q;
    col_d      = col_q;
    vertex_d   = vertex_q;
    col_set_d  = 1'b0;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issue_word = 1'b0;
    mem_rd     = 1'b0;
    iss_tag    = '0;
`ifdef VERTEX_FETCH_INDEX_EN
    idx_addr_d = idx_addr_q;
    go_d       = go_q;
`endif

    // Returns arrive in issue order, so each column/vertex lands contiguously.
    if (ret_valid) begin
      if (ret_kind == TAG_MAT) begin
        col_acc_d[ret_word] = mem_data_in;
        if (ret_word == 2'd3) begin
          col_set_d = 1'b1;
          col_d     = col_acc_d;
        end
      end else if (ret_kind == TAG_VTX) begin
        case (ret_word)
          2'd0:    vtx_acc_d[0] = mem_data_in;
          2'd1:    vtx_acc_d[1] = mem_data_in;
          default: vtx_acc_d[2] = mem_data_in;
        endcase
        if (ret_word == 2'd2) begin
          valid_d  = 1'b1;
          vertex_d = vtx_acc_d;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_in && !done_q) begin
          state_d    = S_MATRIX;
          busy_d     = 1'b1;
          addr_d     = mat_addr_in;
          vtx_addr_d = vtx_addr_in;
          count_d    = count_in;
          vcnt_d     = '0;
          mcnt_d     = '0;
          word_d     = '0;
`ifdef VERTEX_FETCH_INDEX_EN
          idx_addr_d = idx_addr_in;
          go_d       = 1'b0;
`endif
        end
      end

      S_MATRIX: begin
        mem_rd  = 1'b1;
        iss_tag = {TAG_MAT, mcnt_q[1:0]};
        addr_d  = addr_q + ADDR_W'(1);
        mcnt_d  = mcnt_q + 4'd1;
        if (mcnt_q == LAST_MAT) begin
          if (count_q == 16'd0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_VERTS;
`ifdef VERTEX_FETCH_INDEX_EN
            addr_d  = idx_addr_q;
`else
            addr_d  = vtx_addr_q;
`endif
          end
        end
      end

      S_VERTS: begin
`ifdef VERTEX_FETCH_INDEX_EN
        issue_word = (word_q != 2'd0) || go_q;
        if (!issue_word && ready_in) begin
          mem_rd  = 1'b1;
          iss_tag = {TAG_IDX, 2'd0};
          state_d = S_IDX_WAIT;
        end
`else
        issue_word = (word_q != 2'd0) || ready_in;
`endif
        if (issue_word) begin
          mem_rd  = 1'b1;
          iss_tag = {TAG_VTX, word_q};
          addr_d  = addr_q + ADDR_W'(1);
`ifdef VERTEX_FETCH_INDEX_EN
          go_d    = 1'b0;
`endif
          if (word_q == 2'd2) begin
            word_d = 2'd0;
            vcnt_d = vcnt_q + 16'd1;
            if (vcnt_d == count_q) begin
              state_d = S_DRAIN;
            end
`ifdef VERTEX_FETCH_INDEX_EN
            addr_d = idx_addr_q + ADDR_W'(vcnt_d);
`endif
          end else begin
            word_d = word_q + 2'd1;
          end
        end
      end

`ifdef VERTEX_FETCH_INDEX_EN
      S_IDX_WAIT: begin
        if (ret_valid && ret_kind == TAG_IDX) begin
          addr_d  = vtx_addr_q + idx_off;
          go_d    = 1'b1;
          state_d = S_VERTS;
        end
      end
`endif

      S_DRAIN: begin
        if (!inflight) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      vtx_addr_q <= '0;
      count_q    <= '0;
      vcnt_q     <= '0;
      mcnt_q     <= '0;
      word_q     <= '0;
      col_acc_q  <= '0;
      vtx_acc_q  <= '0;
      col_q      <= '0;
      vertex_q   <= '0;
      col_set_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef VERTEX_FETCH_INDEX_EN
      idx_addr_q <= '0;
      go_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vtx_addr_q <= vtx_addr_d;
      count_q    <= count_d;
      vcnt_q     <= vcnt_d;
      mcnt_q     <= mcnt_d;
      word_q     <= word_d;
      col_acc_q  <= col_acc_d;
      vtx_acc_q  <= vtx_acc_d;
      col_q      <= col_d;
      vertex_q   <= vertex_d;
      col_set_q  <= col_set_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef VERTEX_FETCH_INDEX_EN
      idx_addr_q <= idx_addr_d;
      go_q       <= go_d;
`endif
    end
  end

  assign mem_rd_out   = mem_rd;
  assign mem_addr_out = addr_q;
  assign col_set_out  = col_set_q;
  assign col_out      = col_q;
  assign valid_out    = valid_q;
  assign vertex_out   = vertex_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_vertex_fetch.sv
// Bench for vertex_fetch: memory model with fixed read latency, address/column/vertex
// scoreboard derived from memory contents, plus literal pins on known values.
module tb_vertex_fetch;
  import gfx_pkg::*;

  localparam int ADDR_W = 16;
  localparam int LAT    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] mat_addr = '0;
  logic [15:0] vtx_addr = '0;
  logic [15:0] count = '0;
`ifdef VERTEX_FETCH_INDEX_EN
  logic [15:0] idx_addr = '0;
`endif
  logic        mem_rd;
  logic [15:0] mem_addr;
  fp32_t       mem_data;
  logic        col_set;
  vec4_t       col;
  logic        valid;
  vec3_t       vertex;
  logic        busy;
  logic        done;

  vertex_fetch #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_in     (start),
    .mat_addr_in  (mat_addr),
    .vtx_addr_in  (vtx_addr),
`ifdef VERTEX_FETCH_INDEX_EN
    .idx_addr_in  (idx_addr),
`endif
    .count_in     (count),
    .ready_in     (ready),
    .mem_rd_out   (mem_rd),
    .mem_addr_out (mem_addr),
    .mem_data_in  (mem_data),
    .col_set_out  (col_set),
    .col_out      (col),
    .valid_out    (valid),
    .vertex_out   (vertex),
    .busy_out     (busy),
    .done_out     (done)
  );

  always #5 clk = ~clk;

  // Scene memory with a fixed LAT-cycle read pipe
  fp32_t                  mem [0:65535];
  logic [LAT-1:0]         rp_v = '0;
  logic [LAT-1:0][15:0]   rp_a = '0;
  always @(posedge clk) begin
    rp_v[0] <= mem_rd;
    rp_a[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      rp_v[i] <= rp_v[i-1];
      rp_a[i] <= rp_a[i-1];
    end
  end
  assign mem_data = rp_v[LAT-1] ? mem[rp_a[LAT-1]] : 32'hDEAD_BEEF;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_total = 0, colset_total = 0, valid_total = 0, done_total = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  vec4_t first_col;
  bit    first_col_seen = 0;

  logic [15:0] exp_addr [$];
  vec4_t       exp_col  [$];
  vec3_t       exp_vtx  [$];
  logic [15:0] ea;
  vec4_t       ec;
  vec3_t       ev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected read order, columns and vertices from memory contents
  task automatic plan(input logic [15:0] m, input logic [15:0] v, input logic [15:0] n,
                      input logic [15:0] ix);
    logic [15:0] b;
    logic [15:0] ia;
    exp_addr.delete();
    exp_col.delete();
    exp_vtx.delete();
    for (int j = 0; j < 4; j++) begin
      exp_col.push_back({mem[m + 16'(4*j+3)], mem[m + 16'(4*j+2)],
                         mem[m + 16'(4*j+1)], mem[m + 16'(4*j)]});
    end
    for (int w = 0; w < 16; w++) exp_addr.push_back(m + 16'(w));
    for (int i = 0; i < int'(n); i++) begin
      ia = ix + 16'(i);
`ifdef VERTEX_FETCH_INDEX_EN
      exp_addr.push_back(ia);
      b = v + 16'(32'(mem[ia][15:0]) * 3);
`else
      b = v + 16'(3*i) + (ia & 16'h0);
`endif
      for (int k = 0; k < 3; k++) exp_addr.push_back(b + 16'(k));
      exp_vtx.push_back({mem[b + 16'd2], mem[b + 16'd1], mem[b]});
    end
  endtask

  // Single compare process, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mem_rd) begin
        rd_total++;
        if (exp_addr.size() > 0) ea = exp_addr.pop_front(); else ea = 'x;
        check("rd_addr", mem_addr, ea);
      end
      if (col_set) begin
        colset_total++;
        last_beat_cyc = cyc;
        if (!first_col_seen) begin
          first_col = col;
          first_col_seen = 1;
        end
        if (exp_col.size() > 0) ec = exp_col.pop_front(); else ec = 'x;
        check("col_out", col, ec);
      end
      if (valid) begin
        valid_total++;
        last_beat_cyc = cyc;
        if (exp_vtx.size() > 0) ev = exp_vtx.pop_front(); else ev = 'x;
        check("vertex_out", vertex, ev);
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  task automatic fire(input logic [15:0] m, input logic [15:0] v, input logic [15:0] n,
                      input logic [15:0] ix);
    @(posedge clk); #1;
    start = 1'b1;
    mat_addr = m;
    vtx_addr = v;
    count = n;
`ifdef VERTEX_FETCH_INDEX_EN
    idx_addr = ix;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic run(input logic [15:0] m, input logic [15:0] v, input logic [15:0] n,
                     input logic [15:0] ix, input int stall_at, input bit start_at_done,
                     input bit mid_start);
    int  b_rd, b_cs, b_v, b_d, rd_exp;
    int  stall_left;
    bit  done_seen;
    bit  stalled;
    stall_left = 5;
    done_seen = 0;
    plan(m, v, n, ix);
    rd_exp = 16 + 3*int'(n);
`ifdef VERTEX_FETCH_INDEX_EN
    rd_exp = rd_exp + int'(n);
`endif
    b_rd = rd_total; b_cs = colset_total; b_v = valid_total; b_d = done_total;
    fire(m, v, n, ix);
    for (int c = 0; c < 2000 && !done_seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ready = 1'b1;
      stalled = 0;
      if (stall_at > 0 && rd_total - b_rd >= stall_at && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
        stalled = 1;
      end
      if (mid_start && c == 20) begin
        start = 1'b1;
        mat_addr = 16'h0300;
        vtx_addr = 16'h0400;
        count = 16'd9;
      end
      if (done) begin
        done_seen = 1;
        if (start_at_done) start = 1'b1;
      end
      @(negedge clk);
      if (stalled) check("no_rd_while_stalled", mem_rd, 0);
    end
    check("done_seen", done_seen, 1);
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("idle_after_done_busy", busy, 0);
    check("idle_after_done_rd", mem_rd, 0);
    repeat (LAT + 4) @(negedge clk);
    check("col_set_count", colset_total - b_cs, 4);
    check("valid_count", valid_total - b_v, int'(n));
    check("done_count", done_total - b_d, 1);
    check("rd_count", rd_total - b_rd, rd_exp);
    check("done_after_last_beat", done_cyc - last_beat_cyc, 1);
    check("model_drained", exp_addr.size() + exp_col.size() + exp_vtx.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_col_set"}, col_set, 0);
    check({tag, "_col"}, col, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_vertex"}, vertex, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int  b_rd, b_v;
    bit  reached;
    for (int a = 0; a < 65536; a++) mem[a] = {~16'(a), 16'(a)};
    // matrix at 0x10, columns (x,y,z,w): 9,2,1,6 / 6,9,0,3 / 5,1,3,1 / 0,7,5,1
    mem[16'h10] = 32'h41100000; mem[16'h11] = 32'h40000000;
    mem[16'h12] = 32'h3F800000; mem[16'h13] = 32'h40C00000;
    mem[16'h14] = 32'h40C00000; mem[16'h15] = 32'h41100000;
    mem[16'h16] = 32'h00000000; mem[16'h17] = 32'h40400000;
    mem[16'h18] = 32'h40A00000; mem[16'h19] = 32'h3F800000;
    mem[16'h1A] = 32'h40400000; mem[16'h1B] = 32'h3F800000;
    mem[16'h1C] = 32'h00000000; mem[16'h1D] = 32'h40E00000;
    mem[16'h1E] = 32'h40A00000; mem[16'h1F] = 32'h3F800000;
    mem[16'h40] = 32'h40A00000; mem[16'h41] = 32'h3F800000; mem[16'h42] = 32'h40800000;
    mem[16'h200] = 32'h12340002;
    mem[16'h201] = 32'hABCD0000;

    #12;
    check_outputs_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // matrix + one vertex
    run(16'h10, 16'h40, 16'd1, 16'h0, 0, 0, 0);
    check("pin_first_col", first_col, 128'h40C00000_3F800000_40000000_41100000);
    check("pin_last_col", col, 128'h3F800000_40A00000_40E00000_00000000);
    check("pin_vertex", vertex, 96'h40800000_3F800000_40A00000);

    // three vertices, ready low for 5 cycles after vertex 0, start while busy
    run(16'h10, 16'h80, 16'd3, 16'h0, 19, 0, 1);

    // no vertices; start in the done cycle must be ignored
    run(16'h10, 16'h80, 16'd0, 16'h0, 0, 1, 0);

    // async reset mid-VERTS
    plan(16'h10, 16'h80, 16'd4, 16'h0);
    b_rd = rd_total;
    fire(16'h10, 16'h80, 16'd4, 16'h0);
    reached = 0;
    for (int c = 0; c < 300 && !reached; c++) begin
      @(negedge clk);
      if (rd_total - b_rd >= 21) reached = 1;
    end
    check("reach_verts_before_reset", reached, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_addr.delete();
    exp_col.delete();
    exp_vtx.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    b_v = valid_total;
    repeat (LAT + 4) @(negedge clk);
    check("no_beat_after_reset", valid_total - b_v, 0);
    check("idle_after_reset", busy, 0);
    run(16'h10, 16'h40, 16'd1, 16'h0, 0, 0, 0);
    check("pin_vertex_after_reset", vertex, 96'h40800000_3F800000_40A00000);

`ifdef VERTEX_FETCH_INDEX_EN
    // indices {2,0}: vertex at 0x46 then 0x40
    run(16'h10, 16'h40, 16'd2, 16'h200, 0, 0, 0);
    check("pin_index_last_vertex", vertex, 96'h40800000_3F800000_40A00000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
